// File: rtl/uart_tx.sv
// uart_tx: 16x-oversampled UART transmitter with a one-entry holding register and optional parity
module uart_tx #(
  parameter int data_bits  = 8,
  parameter int sb_tick    = 16,
  parameter int parity_en  = 0,
  parameter int parity_odd = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 s_tick,
  input  logic                 tx_start,
  input  logic [data_bits-1:0] tx_din,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 tx_done_tick,
  output logic                 tx
);
  localparam int sw = ($clog2(sb_tick) > 4) ? $clog2(sb_tick) : 4;
  localparam int nw = $clog2(data_bits);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t               r_state, w_state;
  logic [sw-1:0]        r_s, w_s;
  logic [nw-1:0]        r_n, w_n;
  logic [data_bits-1:0] r_shift, w_shift, r_hold;
  logic                 r_hold_valid, r_par, r_tx, r_done, w_load, w_tx, w_done;
  assign tx_ready     = ~r_hold_valid;
  assign tx_busy      = (r_state != IDLE);
  assign tx_done_tick = r_done;
  assign tx           = r_tx;
  always_comb begin
    w_state = r_state;
    w_s     = r_s;
    w_n     = r_n;
    w_shift = r_shift;
    w_load  = 1'b0;
    w_tx    = 1'b1;
    w_done  = 1'b0;
    case (r_state)
      IDLE: if (r_hold_valid) begin
        w_load  = 1'b1;
        w_s     = '0;
        w_state = START;
      end
      START: begin
        w_tx = 1'b0;
        if (s_tick) begin
          w_s = (r_s == sw'(15)) ? '0 : r_s + sw'(1);
          if (r_s == sw'(15)) begin
            w_n     = '0;
            w_state = DATA;
          end
        end
      end
      DATA: begin
        w_tx = r_shift[0];
        if (s_tick) begin
          w_s = (r_s == sw'(15)) ? '0 : r_s + sw'(1);
          if (r_s == sw'(15)) begin
            w_shift = r_shift >> 1;
            w_n     = (r_n == nw'(data_bits - 1)) ? r_n : r_n + nw'(1);
            w_state = (r_n != nw'(data_bits - 1)) ? DATA : (parity_en != 0) ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        w_tx = r_par;
        if (s_tick) begin
          w_s     = (r_s == sw'(15)) ? '0 : r_s + sw'(1);
          w_state = (r_s == sw'(15)) ? STOP : PARITY;
        end
      end
      STOP: if (s_tick) begin
        w_s = (r_s == sw'(sb_tick - 1)) ? '0 : r_s + sw'(1);
        if (r_s == sw'(sb_tick - 1)) begin
          w_done  = 1'b1;
          w_load  = r_hold_valid;
          w_state = r_hold_valid ? START : IDLE;
        end
      end
      default: w_state = IDLE;
    endcase
  end
  // tx is registered from the current state, so the line trails the FSM by one clk
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state      <= IDLE;
      r_s          <= '0;
      r_n          <= '0;
      r_shift      <= '0;
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
      r_par        <= 1'b0;
      r_tx         <= 1'b1;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_s          <= w_s;
      r_n          <= w_n;
      r_tx         <= w_tx;
      r_done       <= w_done;
      r_shift      <= w_load ? r_hold : w_shift;
      r_par        <= w_load ? ((^r_hold) ^ (parity_odd != 0)) : r_par;
      r_hold_valid <= w_load ? 1'b0 : (tx_start | r_hold_valid);
      r_hold       <= (tx_start && !r_hold_valid) ? tx_din : r_hold;
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench driving four uart_tx configurations with shared random stimulus
module tb_uart_tx;
  logic       clk = 1'b0;
  logic       reset_n, s_tick, tx_start, exp_acc, run_tick;
  logic [7:0] tx_din;
  wire  [3:0] w_tx, w_busy, w_ready, w_done;
  int         checks = 0, failures = 0, div = 0, exp_frames = 0, frz_bad = 0;
  int         n_done[4], n_frames[4], qsz[4];
  logic [11:0] snap;
  always #5 clk = ~clk;
  always @(negedge clk)
    if (!run_tick) s_tick = 1'b0;
    else begin
      div    = (div == 3) ? 0 : div + 1;
      s_tick = (div == 0);
    end
  function automatic logic [255:0] frame(input logic [7:0] d, input int p_en, input int p_odd, input int stop_len);
    logic [255:0] f;
    f = '1;
    for (int i = 0; i < 16 * (9 + p_en) + stop_len; i++)
      if (i < 16) f[i] = 1'b0;
      else if (i < 144) f[i] = d[3'((i - 16) / 16)];
      else if (p_en != 0 && i < 160) f[i] = (^d) ^ (p_odd != 0);
    return f;
  endfunction
  for (genvar g = 0; g < 4; g++) begin : gi
    localparam int pe  = (g == 1 || g == 2) ? 1 : 0;
    localparam int po  = (g == 2) ? 1 : 0;
    localparam int sb  = (g == 3) ? 32 : 16;
    localparam int len = 16 * (9 + pe) + sb;
    logic [7:0]   q[$];
    logic [255:0] act, exp_f;
    int           k, done_at, busy_bad;
    bit           in_f, b2b;
    uart_tx #(.data_bits(8), .sb_tick(sb), .parity_en(pe), .parity_odd(po)) u_dut (
      .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .tx_start(tx_start), .tx_din(tx_din),
      .tx_ready(w_ready[g]), .tx_busy(w_busy[g]), .tx_done_tick(w_done[g]), .tx(w_tx[g])
    );
    initial begin
      n_done[g] = 0;
      n_frames[g] = 0;
      qsz[g] = 0;
    end
    always @(posedge clk) if (tx_start && exp_acc) q.push_back(tx_din);
    always @(posedge clk) begin
      #1;
      if (w_done[g]) n_done[g]++;
    end
    always @(posedge clk) if (s_tick) begin
      #1;
      if (!reset_n) begin
        in_f = 0;
        b2b  = 0;
        q.delete();
      end else if (in_f) begin
        act[k] = w_tx[g];
        if (w_done[g]) done_at = k;
        if (k == len - 1) begin
          checks += 4;
          if (act !== exp_f) begin failures++; $display("FAIL frame[%0d]: got %h expected %h", g, act, exp_f); end
          if (done_at != len - 1) begin failures++; $display("FAIL done_pos[%0d]: got %0d expected %0d", g, done_at, len - 1); end
          if (busy_bad != 0) begin failures++; $display("FAIL busy_frame[%0d]: got %0d idle samples expected 0", g, busy_bad); end
          if (w_busy[g] !== (q.size() != 0)) begin failures++; $display("FAIL busy_end[%0d]: got %b expected %b", g, w_busy[g], q.size() != 0); end
          in_f = 0;
          b2b  = (q.size() != 0);
          n_frames[g]++;
        end else if (!w_busy[g]) busy_bad++;
        k++;
      end else if (!w_tx[g]) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_frame[%0d]: got start bit expected idle", g);
        end else begin
          exp_f   = frame(q.pop_front(), pe, po, sb);
          act     = '1;
          act[0]  = 1'b0;
          k       = 1;
          done_at = -1;
          busy_bad = 0;
          in_f    = 1;
        end
        b2b = 0;
      end else if (b2b) begin
        checks++;
        failures++;
        $display("FAIL b2b_gap[%0d]: got idle tick expected start bit", g);
        b2b = 0;
      end
      qsz[g] = q.size();
    end
  end
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, got, want);
    end
  endtask
  task automatic wr(input logic [7:0] d, input logic acc);
    @(negedge clk);
    tx_din   = d;
    tx_start = 1'b1;
    exp_acc  = acc;
    @(negedge clk);
    tx_start = 1'b0;
    exp_acc  = 1'b0;
    if (acc) exp_frames++;
  endtask
  task automatic tk(input int n);
    repeat (4 * n) @(negedge clk);
  endtask
  initial begin
    reset_n = 1'b0; tx_start = 1'b0; tx_din = '0; exp_acc = 1'b0; run_tick = 1'b1; s_tick = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_tx", {28'd0, w_tx}, 32'hF);
    chk("reset_ready", {28'd0, w_ready}, 32'hF);
    chk("reset_busy", {28'd0, w_busy}, 32'h0);
    chk("reset_done", {28'd0, w_done}, 32'h0);
    reset_n = 1'b1;
    wr(8'hA5, 1'b1);
    chk("ready_after_write", {28'd0, w_ready}, 32'h0);
    tk(200);
    chk("busy_idle", {28'd0, w_busy}, 32'h0);
    chk("ready_idle", {28'd0, w_ready}, 32'hF);
    wr(8'h07, 1'b1);
    tk(200);
    wr(8'h55, 1'b1);
    tk(40);
    chk("ready_in_data", {28'd0, w_ready}, 32'hF);
    wr(8'h0F, 1'b1);
    chk("ready_held", {28'd0, w_ready}, 32'h0);
    wr(8'($urandom), 1'b0);
    chk("ready_after_drop", {28'd0, w_ready}, 32'h0);
    tk(400);
    repeat (4) begin
      wr(8'($urandom), 1'b1);
      tk(200);
    end
    wr(8'($urandom), 1'b1);
    tk(50);
    @(posedge clk);
    #1 run_tick = 1'b0;
    repeat (3) @(negedge clk);
    snap = {w_tx, w_busy, w_ready};
    repeat (100) begin
      @(negedge clk);
      if ({w_tx, w_busy, w_ready} !== snap) frz_bad++;
    end
    chk("freeze_stable", frz_bad, 0);
    chk("freeze_busy", {28'd0, w_busy}, 32'hF);
    @(posedge clk);
    #1 run_tick = 1'b1;
    tk(200);
    wr(8'($urandom), 1'b1);
    tk(72);
    wr(8'($urandom), 1'b1);
    exp_frames -= 2;
    reset_n = 1'b0;
    #1;
    chk("midreset_tx", {28'd0, w_tx}, 32'hF);
    chk("midreset_ready", {28'd0, w_ready}, 32'hF);
    chk("midreset_busy", {28'd0, w_busy}, 32'h0);
    chk("midreset_done", {28'd0, w_done}, 32'h0);
    repeat (8) @(negedge clk);
    reset_n = 1'b1;
    wr(8'h3C, 1'b1);
    tk(200);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("frames[%0d]", i), n_frames[i], exp_frames);
      chk($sformatf("done_count[%0d]", i), n_done[i], exp_frames);
      chk($sformatf("queue_left[%0d]", i), qsz[i], 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial UART transmitter: 8N1 by default, with optional even/odd parity and configurable stop-bit length.
- Driven by the same shared 16x oversampling baud tick (s_tick) as the UART receiver; pairs with it to form the UART link.
- A one-entry holding register accepts the next byte while the current frame is shifting, so frames can go back-to-back with no idle gap.

Parameters:
- data_bits, 8, number of data bits per frame (>=2), sent LSB first
- sb_tick, 16, s_ticks spent in the stop state (16 = 1 stop bit, 24 = 1.5, 32 = 2)
- parity_en, 0, 1 inserts a parity bit between the last data bit and stop
- parity_odd, 0, 0 = even parity, 1 = odd parity; ignored when parity_en = 0

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- s_tick  input  1  one-clk pulse at 16x the baud rate
- tx_start  input  1  write strobe for tx_din; accepted only when tx_ready = 1
- tx_din  input  data_bits  byte to transmit
- tx_ready  output  1  holding register empty, so a write will be accepted
- tx_busy  output  1  FSM not in idle (a frame is on the line)
- tx_done_tick  output  1  one-clk pulse when a frame's stop period completes
- tx  output  1  serial line, registered; idles high

Behaviour:
- Reset values (async, while reset_n = 0):
  - Outputs: tx = 1, tx_ready = 1, tx_busy = 0, tx_done_tick = 0.
  - Internal: FSM = idle; hold_valid, shift register, s counter and n counter cleared.
- Reset mid-frame: the line returns high on reset assertion, no tx_done_tick is issued, and the pending hold byte is discarded.
- Counter widths:
  - s counter: max($clog2(sb_tick), 4) bits.
  - n counter: $clog2(data_bits) bits.
- Holding register and handshake:
  - tx_ready = ~hold_valid.
  - tx_start with tx_ready = 1 at edge N captures tx_din; hold_valid = 1 and tx_ready = 0 from N+1.
  - tx_start with tx_ready = 0 is ignored: no capture, no error, the held byte is unchanged.
  - Capture and consume can never coincide, because consume requires hold_valid = 1.
- FSM states: idle, start, data, parity, stop.
  - All counting advances only on clocks with s_tick = 1. With s_tick low the state, counters and tx are frozen.
  - idle:
    - tx = 1.
    - If hold_valid: load shift register from hold, clear hold_valid, s = 0, go to start.
    - Latency: capture at edge N, start at N+1, tx falls at N+2.
  - start:
    - tx = 0 for 16 ticks.
    - On the tick with s = 15: s = 0, n = 0, go to data.
  - data:
    - tx = shift[0] for 16 ticks.
    - On the tick with s = 15: shift right, s = 0.
    - If n = data_bits-1: go to parity if parity_en, else stop. Otherwise n = n+1.
  - parity:
    - tx = (^data) ^ parity_odd, computed from the byte loaded at frame start, for 16 ticks.
    - On the tick with s = 15: s = 0, go to stop.
  - stop:
    - tx = 1 for sb_tick ticks.
    - On the tick with s = sb_tick-1: tx_done_tick = 1 for that clk, s = 0.
    - Then go to start with the hold byte loaded (back-to-back) if hold_valid = 1, else go to idle.
- tx_busy = (state != idle). It stays 1 across back-to-back frames.
- Frame length in ticks: 16·(1 + data_bits + parity_en) + sb_tick.
- Unreachable state encodings return to idle with tx = 1.

Test Plan:
- Single frame, default params, tx_din = 0xA5:
  - tx low for 16 ticks, then bits 1,0,1,0,0,1,0,1 at 16 ticks each, then high for 16 ticks.
  - One tx_done_tick at tick 160; tx_busy returns to 0.
- Back-to-back: write 0x55, then write 0x0F while the first frame is in data.
  - The 0x0F start bit begins on the tick immediately after the 0x55 stop ends, with zero idle ticks; tx_busy never drops.
  - A third write while tx_ready = 0 is dropped; only 2 done pulses occur.
- Parity, parity_en = 1:
  - parity_odd = 0, tx_din = 0x07: parity bit = 1.
  - parity_odd = 1, tx_din = 0x07: parity bit = 0.
  - Frame = 176 ticks.
- sb_tick = 32: the stop period holds tx high for exactly 32 ticks; tx_done_tick fires on the 32nd stop tick.
- Async reset asserted during data bit 3:
  - tx = 1, tx_ready = 1, tx_busy = 0 immediately; no done pulse.
  - A subsequent write of 0x3C transmits a correct full frame.
- s_tick held low for 100 clks mid-frame: tx and all state remain constant; transmission resumes exactly where it stopped.
